// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle RISC-V style core.
// Moore machine: every control output is decoded from the current state,
// except pc_write, which folds in the ALU zero flag for taken branches.
//
// state    | code | meaning
// ---------+------+--------------------------------------------------
// FETCH    |  0   | read instruction at PC, PC <= PC + 4
// DECODE   |  1   | read register file, compute branch/jump target
// MEMADR   |  2   | compute load/store address rs1 + imm
// MEMREAD  |  3   | read data memory at computed address
// MEMWB    |  4   | write loaded data to rd
// MEMWRITE |  5   | write rs2 to data memory
// EXECR    |  6   | R-type ALU operation rs1 op rs2
// ALUWB    |  7   | write ALU result to rd
// EXECI    |  8   | I-type ALU operation rs1 op imm
// JAL      |  9   | rd <= PC + 4, PC <= jump target
// BEQ      | 10   | compare rs1/rs2, PC <= target when equal
// ERROR    | 11   | illegal opcode seen; parked until reset

module multicycle_main_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        zero,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_op,
  output logic        adr_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        pc_write,
  output logic [3:0]  state,
  output logic [63:0] instret,
  output logic        error
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // operand / result mux encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  state_e      state_q;
  state_e      state_d;
  logic [63:0] instret_q;
  logic        error_q;
  logic        retire;

  // raw state decode, before reset gating of the strobes
  logic        ir_write_s;
  logic        reg_write_s;
  logic        mem_write_s;
  logic        pc_update_s;
  logic        branch_s;

  // next-state selection; op only matters when leaving DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LD, OP_SD: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      // unused codes 12-15 recover to FETCH
      default:    state_d = S_FETCH;
    endcase
  end

  // an instruction retires on the edge that takes its last state back to FETCH
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire = 1'b1;
      default:                             retire = 1'b0;
    endcase
  end

  // state, retired count and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= 64'd0;
      error_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + 64'd1;
      end
      if (state_d == S_ERROR) begin
        error_q <= 1'b1;
      end
    end
  end

  // Moore output decode from the current state
  always_comb begin
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    alu_op      = ALUOP_ADD;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURES;
        alu_op      = ALUOP_ADD;
        ir_write_s  = 1'b1;
        pc_update_s = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        result_src  = RES_ALUOUT;
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_s = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        alu_op      = ALUOP_ADD;
        result_src  = RES_ALUOUT;
        pc_update_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch_s   = 1'b1;
      end
      default: begin
        // ERROR and unused codes drive nothing
      end
    endcase
  end

  // Strobes are masked by rst_n directly: FETCH is the reset state and would
  // otherwise assert ir_write/pc_write while reset is still held.
  assign ir_write  = ir_write_s  & rst_n;
  assign reg_write = reg_write_s & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign pc_write  = (pc_update_s | (branch_s & zero)) & rst_n;

  assign state   = state_q;
  assign instret = instret_q;
  assign error   = error_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm with an expected-output scoreboard.
module tb_multicycle_main_fsm;

  logic        clk;
  logic        rst_n;
  logic [6:0]  op;
  logic        zero;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  alu_op;
  logic        adr_src;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        pc_write;
  logic [3:0]  state;
  logic [63:0] instret;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_instret;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] outs;
    logic [13:0] mask;
  } sb_entry_t;

  sb_entry_t sb[$];

  multicycle_main_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .pc_write   (pc_write),
    .state      (state),
    .instret    (instret),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {asa, asb, res, aluop, adr, irw, rw, mw, pcw, err}
  function automatic logic [13:0] exp_vec(input logic [3:0] s, input logic z);
    case (s)
      4'd0:    return 14'b00_10_10_00_0_1_0_0_1_0;
      4'd1:    return 14'b01_01_00_00_0_0_0_0_0_0;
      4'd2:    return 14'b10_01_00_00_0_0_0_0_0_0;
      4'd3:    return 14'b00_00_00_00_1_0_0_0_0_0;
      4'd4:    return 14'b00_00_01_00_0_0_1_0_0_0;
      4'd5:    return 14'b00_00_00_00_1_0_0_1_0_0;
      4'd6:    return 14'b10_00_00_10_0_0_0_0_0_0;
      4'd7:    return 14'b00_00_00_00_0_0_1_0_0_0;
      4'd8:    return 14'b10_01_00_10_0_0_0_0_0_0;
      4'd9:    return 14'b01_10_00_00_0_0_0_0_1_0;
      4'd10:   return {12'b10_00_00_01_0_0_0_0, z, 1'b0};
      4'd11:   return 14'b00_00_00_00_0_0_0_0_0_1;
      default: return 14'd0;
    endcase
  endfunction

  function automatic logic [13:0] obs_vec();
    return {alu_src_a, alu_src_b, result_src, alu_op, adr_src,
            ir_write, reg_write, mem_write, pc_write, error};
  endfunction

  task automatic sb_push(input logic [3:0] s, input logic [13:0] v, input logic [13:0] m);
    sb_entry_t e;
    e.st = s; e.outs = v; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    sb_entry_t e;
    logic [13:0] obs;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty: observed size=%0d expected >0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      obs = obs_vec();
      n_tests++;
      assert (state === e.st) else begin
        n_fail++;
        $error("FAIL %s state observed=%0d expected=%0d", tag, state, e.st);
      end
      n_tests++;
      assert ((obs & e.mask) === (e.outs & e.mask)) else begin
        n_fail++;
        $error("FAIL %s outputs observed=%b expected=%b mask=%b", tag, obs, e.outs, e.mask);
      end
    end
  endtask

  task automatic chk_instret(input string tag);
    n_tests++;
    assert (instret === exp_instret) else begin
      n_fail++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_instret);
    end
  endtask

  // reset view: state FETCH, all strobes and error low
  task automatic chk_reset(input string tag);
    sb_push(4'd0, 14'd0, 14'h001F);
    sb_check(tag);
    chk_instret(tag);
  endtask

  // Drive one instruction; op carries the real opcode only while DECODE and
  // MEMADR are being left, and junk otherwise, so stray sampling shows up.
  task automatic run(input string name, input logic [6:0] op_v, input logic z,
                     input logic [63:0] seq, input int n);
    logic [3:0] s;
    zero = z;
    for (int i = 0; i < n; i++) begin
      s = seq[4*(n-1-i) +: 4];
      sb_push(s, exp_vec(s, z), 14'h3FFF);
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      sb_check($sformatf("%s[%0d]", name, i));
      op = (i == 1 || i == 2) ? op_v : 7'b1111111;
    end
  endtask

  task automatic finish_instr(input string name);
    @(negedge clk);
    exp_instret = exp_instret + 64'd1;
    chk_instret(name);
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 7'b1111111;
    zero  = 1'b0;
    exp_instret = 64'd0;
    #2;
    chk_reset("reset_t2");
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset_clocked");
    rst_n = 1'b1;
    #1;

    run("ld", 7'b0000011, 1'b0, 64'h01234, 5);
    finish_instr("ld_ret");
    run("sd", 7'b0100011, 1'b0, 64'h0125, 4);
    finish_instr("sd_ret");
    run("rtype", 7'b0110011, 1'b0, 64'h0167, 4);
    finish_instr("rtype_ret");
    run("ialu", 7'b0010011, 1'b0, 64'h0187, 4);
    finish_instr("ialu_ret");
    run("jal", 7'b1101111, 1'b0, 64'h0197, 4);
    finish_instr("jal_ret");
    run("beq_taken", 7'b1100011, 1'b1, 64'h01A, 3);
    finish_instr("beq_taken_ret");
    run("beq_not", 7'b1100011, 1'b0, 64'h01A, 3);
    finish_instr("beq_not_ret");

    // illegal opcode parks in ERROR; async reset clears it without a clock
    run("illegal", 7'b1111111, 1'b0, 64'h01BBBBBBBBBBBB, 14);
    chk_instret("illegal_noret");
    #2;
    rst_n = 1'b0;
    exp_instret = 64'd0;
    #1;
    chk_reset("reset_from_error");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // abort a load in MEMREAD, then continue with normal instructions
    run("ld_abort", 7'b0000011, 1'b0, 64'h0123, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid_memread");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run("sd_after", 7'b0100011, 1'b0, 64'h0125, 4);
    finish_instr("sd_after_ret");
    run("ld_after", 7'b0000011, 1'b0, 64'h01234, 5);
    finish_instr("ld_after_ret");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
